led_pattern_sequencer: RTL and testbench

//   Controller for the board's 4 LEDs. Replaces the free-running ripple divider.

---
 rtl/led_pattern_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives the board's 4 LEDs through one of four patterns (COUNT, CHASE,
//   BOUNCE, BLINK). A synchronous prescaler produces a base tick. A 2^speed
//   divider stretches that tick into the pattern step. Two debounced
//   active-low buttons cycle the mode and the speed. Everything runs on CLK.
//
//   Ports
//     CLK        in   system clock
//     RST_N      in   asynchronous active-low reset
//     KEY_MODE   in   mode button, active-low, asynchronous to CLK
//     KEY_SPEED  in   speed button, active-low, asynchronous to CLK
//     LED[3:0]   out  registered LED drive
//     MODE[1:0]  out  current mode: 0 COUNT, 1 CHASE, 2 BOUNCE, 3 BLINK
//
//   Build option
//     LED_ACTIVE_LOW_EN  when defined, LED = ~pattern and LED resets to 4'b1111.
//                        The pattern, MODE and timing do not change.
module led_pattern_sequencer #(
  parameter int CLK_HZ  = 50000000,
  parameter int STEP_MS = 100,
  parameter int DEB_MS  = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       KEY_MODE,
  input  logic       KEY_SPEED,
  output logic [3:0] LED,
  output logic [1:0] MODE
);

  localparam int unsigned T_STEP = CLK_HZ / 1000 * STEP_MS;
  localparam int unsigned T_DEB  = CLK_HZ / 1000 * DEB_MS;
  localparam int CW = (T_STEP > 1) ? $clog2(T_STEP) : 1;
  localparam int DW = (T_DEB  > 1) ? $clog2(T_DEB)  : 1;

  typedef enum logic [1:0] {
    S_COUNT  = 2'd0,
    S_CHASE  = 2'd1,
    S_BOUNCE = 2'd2,
    S_BLINK  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Key path. Bit 0 is KEY_MODE and bit 1 is KEY_SPEED.
  // ---------------------------------------------------------------------------
  logic [1:0]    w_keys;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_stable;
  logic [1:0]    r_stable_d;
  logic [DW-1:0] r_deb_cnt [2];
  logic [1:0]    w_press;

  assign w_keys = {KEY_SPEED, KEY_MODE};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      for (int unsigned k = 0; k < 2; k++) r_deb_cnt[k] <= '0;
    end else begin
      r_sync1    <= w_keys;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int unsigned k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_deb_cnt[k] <= '0;
        end else if (r_deb_cnt[k] == DW'(T_DEB - 1)) begin
          r_stable[k]  <= r_sync2[k];
          r_deb_cnt[k] <= '0;
        end else begin
          r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  // The press pulse is high for one cycle on a falling edge of the stable level.
  assign w_press = r_stable_d & ~r_stable;

  logic w_press_mode;
  logic w_press_speed;
  assign w_press_mode  = w_press[0];
  assign w_press_speed = w_press[1];

  // ---------------------------------------------------------------------------
  // Prescaler, speed select and step divider
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_div;
  logic [1:0]    r_speed;
  logic          w_base_tick;
  logic [2:0]    w_div_max;
  logic          w_step;

  assign w_base_tick = (r_cnt == CW'(T_STEP - 1));

  always_comb begin
    w_div_max = 3'd0;
    case (r_speed)
      2'd0: w_div_max = 3'd0;
      2'd1: w_div_max = 3'd1;
      2'd2: w_div_max = 3'd3;
      2'd3: w_div_max = 3'd7;
      default: w_div_max = 3'd0;
    endcase
  end

  assign w_step = w_base_tick && (r_div == w_div_max);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= '0;
      r_div   <= '0;
      r_speed <= '0;
    end else begin
      if (w_press_mode || w_base_tick) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;

      // A mode press or a speed press restarts the divider. Only a mode
      // press also restarts the prescaler.
      if (w_press_mode || w_press_speed) r_div <= '0;
      else if (w_base_tick)              r_div <= (r_div == w_div_max) ? 3'd0 : r_div + 1'b1;

      if (w_press_speed) r_speed <= r_speed + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM and pattern generation
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_pattern;
  logic [3:0] w_pat_nxt;
  logic       r_dir;      // 0 = shifting left, 1 = shifting right
  logic       w_dir_nxt;
  logic [3:0] r_led;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_COUNT;
      r_pattern <= '0;
      r_dir     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pattern <= w_pat_nxt;
      r_dir     <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pattern;
    w_dir_nxt   = r_dir;
    // A reload takes priority over a step that falls in the same cycle.
    if (w_press_mode) begin
      w_dir_nxt = 1'b0;
      case (r_state)
        S_COUNT:  begin w_state_nxt = S_CHASE;  w_pat_nxt = 4'b0001; end
        S_CHASE:  begin w_state_nxt = S_BOUNCE; w_pat_nxt = 4'b0001; end
        S_BOUNCE: begin w_state_nxt = S_BLINK;  w_pat_nxt = 4'b1111; end
        S_BLINK:  begin w_state_nxt = S_COUNT;  w_pat_nxt = 4'b0000; end
        default:  begin w_state_nxt = S_COUNT;  w_pat_nxt = 4'b0000; end
      endcase
    end else if (w_step) begin
      case (r_state)
        S_COUNT: w_pat_nxt = r_pattern + 4'd1;
        S_CHASE: w_pat_nxt = {r_pattern[2:0], r_pattern[3]};
        S_BOUNCE: begin
          // Each end turns the direction around, so an end value never repeats.
          if (!r_dir) begin
            if (r_pattern == 4'b1000) begin
              w_pat_nxt = 4'b0100;
              w_dir_nxt = 1'b1;
            end else begin
              w_pat_nxt = r_pattern << 1;
            end
          end else begin
            if (r_pattern == 4'b0001) begin
              w_pat_nxt = 4'b0010;
              w_dir_nxt = 1'b0;
            end else begin
              w_pat_nxt = r_pattern >> 1;
            end
          end
        end
        S_BLINK: w_pat_nxt = ~r_pattern;
        default: w_pat_nxt = r_pattern;
      endcase
    end
  end

  // The LED register loads from the next pattern. It therefore changes on
  // the same edge as the pattern, which is the cycle after the step pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
`ifdef LED_ACTIVE_LOW_EN
      r_led <= '1;
`else
      r_led <= '0;
`endif
    end else begin
`ifdef LED_ACTIVE_LOW_EN
      r_led <= ~w_pat_nxt;
`else
      r_led <= w_pat_nxt;
`endif
    end
  end

  assign LED  = r_led;
  assign MODE = r_state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Testbench for led_pattern_sequencer with T_STEP = 10 and T_DEB = 10 cycles.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled on
// the falling edge. The LED expectations follow LED_ACTIVE_LOW_EN.
module tb_led_pattern_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       KEY_MODE;
  logic       KEY_SPEED;
  logic [3:0] LED;
  logic [1:0] MODE;

  int checks = 0;
  int errors = 0;

  led_pattern_sequencer #(
    .CLK_HZ (10000),
    .STEP_MS(1),
    .DEB_MS (1)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .KEY_MODE (KEY_MODE),
    .KEY_SPEED(KEY_SPEED),
    .LED      (LED),
    .MODE     (MODE)
  );

  always #5 CLK = ~CLK;

  // Maps a pattern to the LED value expected for the current build.
  function automatic logic [3:0] lv(input logic [3:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic press_mode();
    @(posedge CLK); #1 KEY_MODE = 1'b0;
    repeat (13) @(posedge CLK);
    #1 KEY_MODE = 1'b1;
    @(negedge CLK);
  endtask

  task automatic press_speed();
    @(posedge CLK); #1 KEY_SPEED = 1'b0;
    repeat (14) @(posedge CLK);
    #1 KEY_SPEED = 1'b1;
    repeat (14) @(posedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; KEY_MODE = 1'b1; KEY_SPEED = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (LED !== lv(4'b0000)) begin errors++; $display("FAIL reset_led: got %b want %b", LED, lv(4'b0000)); end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", MODE); end
    @(posedge CLK); #1 RST_N = 1'b1;
  endtask

  task automatic test_count();
    logic [3:0] e;
    for (int k = 1; k <= 16; k++) begin
      e = 4'(k - 1);
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      checks++; if (LED !== lv(e)) begin errors++; $display("FAIL count_hold%0d: got %b want %b", k, LED, lv(e)); end
      e = 4'(k);
      @(posedge CLK);
      @(negedge CLK);
      checks++; if (LED !== lv(e)) begin errors++; $display("FAIL count_step%0d: got %b want %b", k, LED, lv(e)); end
    end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL count_mode: got %0d want 0", MODE); end
  endtask

  task automatic test_chase();
    @(posedge CLK); #1 KEY_MODE = 1'b0;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL chase_early_mode: got %0d want 0", MODE); end
    @(posedge CLK); @(negedge CLK);
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL chase_mode: got %0d want 1", MODE); end
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL chase_load: got %b want %b", LED, lv(4'b0001)); end
    repeat (9) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL chase_hold: got %b want %b", LED, lv(4'b0001)); end
    @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0010)) begin errors++; $display("FAIL chase_s1: got %b want %b", LED, lv(4'b0010)); end
    repeat (7) @(posedge CLK);
    #1 KEY_MODE = 1'b1;
    repeat (3) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0100)) begin errors++; $display("FAIL chase_s2: got %b want %b", LED, lv(4'b0100)); end
    repeat (10) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b1000)) begin errors++; $display("FAIL chase_s3: got %b want %b", LED, lv(4'b1000)); end
    repeat (10) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL chase_wrap: got %b want %b", LED, lv(4'b0001)); end
  endtask

  task automatic test_glitch();
    @(posedge CLK); #1 KEY_MODE = 1'b0;
    repeat (5) @(posedge CLK);
    #1 KEY_MODE = 1'b1;
    repeat (3) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL glitch_hold: got %b want %b", LED, lv(4'b0001)); end
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL glitch_mode: got %0d want 1", MODE); end
    @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0010)) begin errors++; $display("FAIL glitch_step: got %b want %b", LED, lv(4'b0010)); end
    repeat (10) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0100)) begin errors++; $display("FAIL glitch_step2: got %b want %b", LED, lv(4'b0100)); end
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL glitch_mode2: got %0d want 1", MODE); end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [7];
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    press_mode();
    checks++; if (MODE !== 2'd2) begin errors++; $display("FAIL bounce_mode: got %0d want 2", MODE); end
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL bounce_load: got %b want %b", LED, lv(4'b0001)); end
    repeat (9) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL bounce_hold: got %b want %b", LED, lv(4'b0001)); end
    @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(exp_seq[0])) begin errors++; $display("FAIL bounce_s0: got %b want %b", LED, lv(exp_seq[0])); end
    for (int k = 1; k < 7; k++) begin
      repeat (10) @(posedge CLK); @(negedge CLK);
      checks++; if (LED !== lv(exp_seq[k])) begin errors++; $display("FAIL bounce_s%0d: got %b want %b", k, LED, lv(exp_seq[k])); end
    end
  endtask

  task automatic test_blink();
    logic [3:0] e;
    press_mode();
    checks++; if (MODE !== 2'd3) begin errors++; $display("FAIL blink_mode: got %0d want 3", MODE); end
    checks++; if (LED !== lv(4'b1111)) begin errors++; $display("FAIL blink_load: got %b want %b", LED, lv(4'b1111)); end
    for (int k = 0; k < 3; k++) begin
      e = (k % 2 == 0) ? 4'b0000 : 4'b1111;
      repeat (10) @(posedge CLK); @(negedge CLK);
      checks++; if (LED !== lv(e)) begin errors++; $display("FAIL blink_s%0d: got %b want %b", k, LED, lv(e)); end
    end
    press_mode();
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL blink_to_count_mode: got %0d want 0", MODE); end
    checks++; if (LED !== lv(4'b0000)) begin errors++; $display("FAIL blink_to_count_led: got %b want %b", LED, lv(4'b0000)); end
  endtask

  task automatic test_speed();
    logic [3:0] prev;
    logic [3:0] e;
    logic       found;
    int         n;
    press_speed();
    press_speed();
    prev = LED; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      if (LED !== prev) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL speed_first_step: got no change want change within 100 cycles"); end
    for (int k = 0; k < 2; k++) begin
      prev = LED; e = lv(lv(prev) + 4'd1); found = 1'b0; n = 0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge CLK);
        n++;
        if (LED !== prev) found = 1'b1;
      end
      checks++; if (n != 40 || !found) begin errors++; $display("FAIL speed_interval%0d: got %0d want 40 cycles", k, n); end
      checks++; if (LED !== e) begin errors++; $display("FAIL speed_value%0d: got %b want %b", k, LED, e); end
    end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL speed_mode: got %0d want 0", MODE); end
  endtask

  // Both keys together: mode goes COUNT to CHASE and speed goes 2 to 3 (period 80).
  task automatic test_simultaneous();
    @(posedge CLK); #1 KEY_MODE = 1'b0; KEY_SPEED = 1'b0;
    repeat (13) @(posedge CLK);
    #1 KEY_MODE = 1'b1; KEY_SPEED = 1'b1;
    @(negedge CLK);
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL simul_mode: got %0d want 1", MODE); end
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL simul_load: got %b want %b", LED, lv(4'b0001)); end
    repeat (79) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL simul_hold: got %b want %b", LED, lv(4'b0001)); end
    @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0010)) begin errors++; $display("FAIL simul_step: got %b want %b", LED, lv(4'b0010)); end
  endtask

  task automatic test_reset_mid();
    repeat (5) @(posedge CLK);
    #1 RST_N = 1'b0;
    #2;
    checks++; if (LED !== lv(4'b0000)) begin errors++; $display("FAIL rstmid_led: got %b want %b", LED, lv(4'b0000)); end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL rstmid_mode: got %0d want 0", MODE); end
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (9) @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0000)) begin errors++; $display("FAIL rstmid_hold: got %b want %b", LED, lv(4'b0000)); end
    @(posedge CLK); @(negedge CLK);
    checks++; if (LED !== lv(4'b0001)) begin errors++; $display("FAIL rstmid_step: got %b want %b", LED, lv(4'b0001)); end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL rstmid_mode2: got %0d want 0", MODE); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_chase();
    test_glitch();
    test_bounce();
    test_blink();
    test_speed();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
